// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the drain controller, the penalty-box FIFO read port
// and the downstream valid/ready stream consumer.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 72
);
  logic                  fifo_empty;
  logic                  fifo_rd_cs;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_cs, fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_cs, fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller: pops FIFO entries, absorbs the one-cycle read
// latency into a 2-entry output buffer and presents them on a valid/ready
// stream. A flush discards everything buffered or still queued in the FIFO.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 72,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_rd_stream_if.master     bus,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drained_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  deq;
  logic                  m_valid;
  logic                  flush_exit;
  logic [2:0]            pending;

  assign m_valid = (state_q == RUN) && (occ_q != 2'd0);
  assign deq     = m_valid && bus.m_ready;

  // Entries the buffer will hold once this cycle's handshake and in-flight read settle
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};

  // Next-state, pop decision and buffer shuffle for the RUN/FLUSH controller
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pop        = 1'b0;
    flush_exit = 1'b0;
    case (state_q)
      RUN: begin
        pop = !bus.fifo_empty && (pending <= 3'd1);
        if (flush) begin
          state_d = FLUSH;
          occ_d   = 2'd0;
        end else begin
          case ({inflight_q, deq})
            2'b10: begin
              if (occ_q == 2'd0) head_d = bus.fifo_data;
              else               tail_d = bus.fifo_data;
              occ_d = occ_q + 2'd1;
            end
            2'b01: begin
              head_d = tail_q;
              occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
              if (occ_q == 2'd2) begin
                head_d = tail_q;
                tail_d = bus.fifo_data;
              end else begin
                head_d = bus.fifo_data;
              end
            end
            default: ;
          endcase
        end
      end
      FLUSH: begin
        pop = !bus.fifo_empty;
        if (bus.fifo_empty && !inflight_q) begin
          state_d    = RUN;
          flush_exit = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, buffer, in-flight tracker, flush pulse and delivery counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      flush_done  <= 1'b0;
      drained_cnt <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      inflight_q  <= pop;
      head_q      <= head_d;
      tail_q      <= tail_d;
      flush_done  <= flush_exit;
      drained_cnt <= drained_cnt + {{(CNT_WIDTH-1){1'b0}}, deq};
    end
  end

  // Reset masks the pop so the FIFO is never read while the block is held in reset
  assign bus.fifo_rd_cs = pop && !rst;
  assign bus.fifo_rd_en = pop && !rst;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = head_q;
  assign busy           = (state_q == FLUSH) || (occ_q != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a behavioural FIFO feeds the DUT, the
// stimulus side queues the entries expected on the stream, and a monitor
// compares every stream handshake against that queue.
module tb_fifo_rd_stream;
  localparam int DW = 72;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          flush_done;
  logic          busy;
  logic [CW-1:0] drained_cnt;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .flush_done  (flush_done),
    .busy        (busy),
    .drained_cnt (drained_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  int            wr_ptr  = 0;
  int            rd_ptr  = 0;
  int            pop_cnt = 0;
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            base;
  int            n_written;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  // Behavioural FIFO read port: registered data one cycle after each pop
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= 0;
      bus.fifo_data <= '0;
    end else if (bus.fifo_rd_en && bus.fifo_rd_cs) begin
      bus.fifo_data <= mem[rd_ptr[9:0]];
      rd_ptr        <= rd_ptr + 1;
      pop_cnt       <= pop_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input bit deliver);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
    if (deliver) exp_q.push_back(d);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_cs"}, DW'(bus.fifo_rd_cs), DW'(0));
    checkOutput({tag, "_rd_en"}, DW'(bus.fifo_rd_en), DW'(0));
    checkOutput({tag, "_m_valid"}, DW'(bus.m_valid), DW'(0));
    checkOutput({tag, "_m_data"}, bus.m_data, DW'(0));
    checkOutput({tag, "_flush_done"}, DW'(flush_done), DW'(0));
    checkOutput({tag, "_busy"}, DW'(busy), DW'(0));
    checkOutput({tag, "_drained_cnt"}, DW'(drained_cnt), DW'(0));
  endtask

  // Stream monitor: every handshake must match the oldest expected entry
  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL stream_beat: got data 0x%0h, expected no beat", bus.m_data);
      end else begin
        checkOutput("stream_data", bus.m_data, exp_q.pop_front());
      end
    end
  end

  // Watchdog so a stalled DUT still ends the run
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");

    // Single entry, written while still in reset
    applyStimulus(DW'(8'hA5), 1'b1);
    bus.m_ready = 1'b1;
    #1;
    checkOutput("rd_en_in_reset", DW'(bus.fifo_rd_en), DW'(0));
    @(negedge clk);
    rst  = 1'b0;
    base = pop_cnt;
    @(negedge clk);
    checkOutput("single_valid_t1", DW'(bus.m_valid), DW'(0));
    checkOutput("single_pops_t1", DW'(pop_cnt - base), DW'(1));
    @(negedge clk);
    checkOutput("single_valid_t2", DW'(bus.m_valid), DW'(1));
    checkOutput("single_data_t2", bus.m_data, DW'(8'hA5));
    repeat (4) @(negedge clk);
    checkOutput("single_drained", DW'(drained_cnt), DW'(1));
    checkOutput("single_pops", DW'(pop_cnt - base), DW'(1));
    checkOutput("single_busy", DW'(busy), DW'(0));

    // Burst of 8 at full rate
    base = pop_cnt;
    for (int i = 0; i < 8; i++) applyStimulus(DW'(i), 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("burst_pops_4", DW'(pop_cnt - base), DW'(4));
    repeat (5) @(negedge clk);
    checkOutput("burst_busy_last", DW'(busy), DW'(1));
    @(negedge clk);
    checkOutput("burst_busy_after", DW'(busy), DW'(0));
    checkOutput("burst_drained", DW'(drained_cnt), DW'(9));
    checkOutput("burst_pops", DW'(pop_cnt - base), DW'(8));

    // Backpressure: only two entries leave the FIFO
    bus.m_ready = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 6; i++) applyStimulus(DW'(i), 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("bp_pops", DW'(pop_cnt - base), DW'(2));
    checkOutput("bp_valid", DW'(bus.m_valid), DW'(1));
    checkOutput("bp_data", bus.m_data, DW'(0));
    repeat (5) @(negedge clk);
    checkOutput("bp_data_stable", bus.m_data, DW'(0));
    bus.m_ready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("bp_pops_total", DW'(pop_cnt - base), DW'(6));
    checkOutput("bp_drained", DW'(drained_cnt), DW'(15));
    checkOutput("bp_busy", DW'(busy), DW'(0));

    // Empty FIFO: no pops, no data
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("empty_rd_en", DW'(bus.fifo_rd_en), DW'(0));
      checkOutput("empty_valid", DW'(bus.m_valid), DW'(0));
    end

    // Flush with a full buffer and five entries still queued
    bus.m_ready = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 7; i++) applyStimulus(DW'(8'h40 + i), 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("flush_pre_pops", DW'(pop_cnt - base), DW'(2));
    checkOutput("flush_pre_busy", DW'(busy), DW'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_valid_drop", DW'(bus.m_valid), DW'(0));
    checkOutput("flush_busy", DW'(busy), DW'(1));
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("flush_done_c%0d", k), DW'(flush_done), DW'(k == 8));
    end
    checkOutput("flush_pops", DW'(pop_cnt - base), DW'(7));
    checkOutput("flush_drained", DW'(drained_cnt), DW'(15));
    checkOutput("flush_busy_after", DW'(busy), DW'(0));
    bus.m_ready = 1'b1;
    applyStimulus(DW'(8'h3C), 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("post_flush_drained", DW'(drained_cnt), DW'(16));
    checkOutput("post_flush_pops", DW'(pop_cnt - base), DW'(8));

    // Counter wrap: bring the count to 65535, then one more
    n_written = 0;
    for (int cyc = 0; cyc < 70000 && n_written < 65519; cyc++) begin
      @(negedge clk);
      if (wr_ptr - rd_ptr < 4) begin
        applyStimulus(DW'(n_written) + 72'h1000, 1'b1);
        n_written++;
      end
    end
    checkOutput("wrap_writes", DW'(n_written), DW'(65519));
    repeat (10) @(negedge clk);
    checkOutput("wrap_pre", DW'(drained_cnt), DW'(16'hFFFF));
    applyStimulus(DW'(16'hBEEF), 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("wrap_zero", DW'(drained_cnt), DW'(0));

    // Reset in the middle of a burst
    for (int i = 0; i < 8; i++) applyStimulus(DW'(12'h200 + i), 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_delivered", DW'(exp_q.size()), DW'(6));
    #4;
    rst    = 1'b1;
    wr_ptr = 0;
    exp_q.delete();
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("after_reset_busy", DW'(busy), DW'(0));
    checkOutput("after_reset_valid", DW'(bus.m_valid), DW'(0));
    checkOutput("after_reset_drained", DW'(drained_cnt), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
